// File: rtl/soqpsk_argmax_tree_pkg.sv
// Shared types and helpers for the SOQPSK signed argmax tree.
// Compare helper works on a wide signed type so any metric width up to 64 bits fits.
package soqpsk_argmax_pkg;

    localparam int CMP_W = 64;
    typedef logic signed [CMP_W-1:0] cmp_t;

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_OPEN = 1'b1
    } frame_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // True when b >= a, so b (the higher-index candidate) wins ties.
    function automatic logic signed_ge(input cmp_t a, input cmp_t b);
        return (b >= a);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/soqpsk_argmax_tree_if.sv
// Beat input / frame result bundle for soqpsk_argmax_tree.
interface soqpsk_argmax_tree_if #(
    parameter int WIDTH = 12,
    parameter int N_IN  = 8,
    parameter int IDX_W = 5
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_max;
    logic [IDX_W-1:0]      out_index;
    logic                  out_overflow;

    modport master (
        output in_valid, in_first, in_last, in_data,
        input  out_valid, out_max, out_index, out_overflow
    );

    modport slave (
        input  in_valid, in_first, in_last, in_data,
        output out_valid, out_max, out_index, out_overflow
    );
endinterface

// File: rtl/soqpsk_argmax_tree_node.sv
// One registered pairwise signed compare; operand b is the higher lane index.
module soqpsk_argmax_node
    import soqpsk_argmax_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int LANE_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic signed [WIDTH-1:0]  a_val_i,
    input  logic        [LANE_W-1:0] a_idx_i,
    input  logic signed [WIDTH-1:0]  b_val_i,
    input  logic        [LANE_W-1:0] b_idx_i,
    output logic                     valid_o,
    output logic signed [WIDTH-1:0]  val_o,
    output logic        [LANE_W-1:0] idx_o
);

    logic                     pick_b;
    logic                     valid_q;
    logic signed [WIDTH-1:0]  val_q;
    logic        [LANE_W-1:0] idx_q;

    always_comb pick_b = signed_ge(cmp_t'(a_val_i), cmp_t'(b_val_i));

    // NOTE: non-blocking assignments make every tree level sample the previous level's old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                val_q <= pick_b ? b_val_i : a_val_i;
                idx_q <= pick_b ? b_idx_i : a_idx_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign val_o   = val_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/soqpsk_argmax_tree.sv
// Pipelined signed argmax over N_IN lanes per beat with a running max across a frame.
// Tree is a heap of registered nodes: node i has children 2i+1 (lower lane) and 2i+2.
module soqpsk_argmax_tree
    import soqpsk_argmax_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int N_IN         = 8,
    parameter int MAX_BEATS    = 4,
    parameter int IDX_W        = 5,
    parameter int INDEX_OFFSET = 0
) (
    input  logic           clk,
    input  logic           reset,
    soqpsk_argmax_tree_if.slave bus
);

    localparam int L     = clog2(N_IN);
    localparam int LW    = L;
    localparam int BW    = (MAX_BEATS > 1) ? clog2(MAX_BEATS) : 1;
    localparam int POS_W = BW + LW;
    localparam int NODES = 2 * N_IN - 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    typedef struct packed {
        logic          first;
        logic          last;
        logic          ovf;
        logic [BW-1:0] beat;
    } sb_t;

    frame_state_e state_q, state_d;
    logic         accept;
    logic [BW-1:0] beat_q, beat_d;
    logic          sat_q, sat_d;
    sb_t           sb_in;
    sb_t           sb_q [L];
    sb_t           sb_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FRAME_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = bus.in_last ? FRAME_IDLE : FRAME_OPEN;
    end

    always_comb accept = bus.in_valid & (bus.in_first | (state_q == FRAME_OPEN));

    // Beat number for the current beat; once it sits at LAST_BEAT every further beat overflows.
    always_comb begin
        sb_in       = '0;
        sb_in.first = bus.in_first;
        sb_in.last  = bus.in_last;
        sb_in.beat  = bus.in_first ? '0 : beat_q;
        sb_in.ovf   = bus.in_first ? 1'b0 : sat_q;
        beat_d      = beat_q;
        sat_d       = sat_q;
        if (accept) begin
            if (sb_in.beat == LAST_BEAT) begin
                beat_d = LAST_BEAT;
                sat_d  = 1'b1;
            end else begin
                beat_d = sb_in.beat + BW'(1);
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
            sat_q  <= 1'b0;
            for (int s = 0; s < L; s++) sb_q[s] <= '0;
        end else begin
            beat_q  <= beat_d;
            sat_q   <= sat_d;
            sb_q[0] <= sb_in;
            for (int s = 1; s < L; s++) sb_q[s] <= sb_q[s-1];
        end
    end

    assign sb_o = sb_q[L-1];

    logic signed [WIDTH-1:0] t_val [NODES];
    logic        [LW-1:0]    t_idx [NODES];
    logic                    t_vld [NODES];

    for (genvar k = 0; k < N_IN; k++) begin : g_leaf
        assign t_val[N_IN-1+k] = bus.in_data[lane_lsb(k, WIDTH) +: WIDTH];
        assign t_idx[N_IN-1+k] = LW'(k);
        assign t_vld[N_IN-1+k] = accept;
    end

    for (genvar i = 0; i < N_IN - 1; i++) begin : g_node
        soqpsk_argmax_node #(
            .WIDTH  (WIDTH),
            .LANE_W (LW)
        ) u_node (
            .clk     (clk),
            .reset   (reset),
            .valid_i (t_vld[2*i+1] & t_vld[2*i+2]),
            .a_val_i (t_val[2*i+1]),
            .a_idx_i (t_idx[2*i+1]),
            .b_val_i (t_val[2*i+2]),
            .b_idx_i (t_idx[2*i+2]),
            .valid_o (t_vld[i]),
            .val_o   (t_val[i]),
            .idx_o   (t_idx[i])
        );
    end

    logic signed [WIDTH-1:0] acc_max_q, new_max;
    logic        [POS_W-1:0] acc_pos_q, new_pos;
    logic                    acc_ovf_q, new_ovf;
    logic                    take;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_max_q;
    logic        [IDX_W-1:0] out_index_q;
    logic                    out_ovf_q;

    always_comb begin
        take    = sb_o.first | signed_ge(cmp_t'(acc_max_q), cmp_t'(t_val[0]));
        new_max = take ? t_val[0] : acc_max_q;
        new_pos = take ? {sb_o.beat, t_idx[0]} : acc_pos_q;
        new_ovf = sb_o.ovf | (~sb_o.first & acc_ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_max_q   <= '0;
            acc_pos_q   <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_index_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= t_vld[0] & sb_o.last;
            if (t_vld[0]) begin
                acc_max_q <= new_max;
                acc_pos_q <= new_pos;
                acc_ovf_q <= new_ovf;
                if (sb_o.last) begin
                    out_max_q   <= new_max;
                    out_index_q <= IDX_W'(INDEX_OFFSET) + IDX_W'(new_pos);
                    out_ovf_q   <= new_ovf;
                end
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_max      = out_max_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_soqpsk_argmax_tree.sv
// Directed bench: three argmax instances (default, INDEX_OFFSET=2, MAX_BEATS=2) share one stimulus.
module tb_soqpsk_argmax_tree;

    typedef struct {
        int         cyc;
        logic [11:0] mx;
        logic [5:0]  idx;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [95:0] d;
        logic [11:0] mx;
        int          idx;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid, in_first, in_last;
    logic [95:0] in_data;
    int          cyc;
    int          drv_cyc;
    int          n_checks;
    int          n_errors;
    res_t        e0[$], e1[$], e2[$], o0[$], o1[$], o2[$];
    vec_t        tbl[8];

    soqpsk_argmax_tree_if #(.WIDTH(12), .N_IN(8), .IDX_W(5)) if0 ();
    soqpsk_argmax_tree_if #(.WIDTH(12), .N_IN(8), .IDX_W(6)) if1 ();
    soqpsk_argmax_tree_if #(.WIDTH(12), .N_IN(8), .IDX_W(5)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.in_first = in_first;
    assign if0.in_last  = in_last;   assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;  assign if1.in_first = in_first;
    assign if1.in_last  = in_last;   assign if1.in_data  = in_data;
    assign if2.in_valid = in_valid;  assign if2.in_first = in_first;
    assign if2.in_last  = in_last;   assign if2.in_data  = in_data;

    soqpsk_argmax_tree #(.WIDTH(12), .N_IN(8), .MAX_BEATS(4), .IDX_W(5), .INDEX_OFFSET(0))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    soqpsk_argmax_tree #(.WIDTH(12), .N_IN(8), .MAX_BEATS(4), .IDX_W(6), .INDEX_OFFSET(2))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    soqpsk_argmax_tree #(.WIDTH(12), .N_IN(8), .MAX_BEATS(2), .IDX_W(5), .INDEX_OFFSET(0))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t mk(input int c, input logic [11:0] m, input int i, input logic v);
        res_t r;
        r.cyc = c;
        r.mx  = m;
        r.idx = 6'(i);
        r.ovf = v;
        return r;
    endfunction

    always @(negedge clk) begin
        if (if0.out_valid) o0.push_back(mk(cyc, if0.out_max, int'(if0.out_index), if0.out_overflow));
        if (if1.out_valid) o1.push_back(mk(cyc, if1.out_max, int'(if1.out_index), if1.out_overflow));
        if (if2.out_valid) o2.push_back(mk(cyc, if2.out_max, int'(if2.out_index), if2.out_overflow));
    end

    function automatic logic [95:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int          a[8];
        logic [95:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int k = 0; k < 8; k++) r[k*12 +: 12] = a[k][11:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic f, input logic l, input logic [95:0] d);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_data  = d;
        drv_cyc  = cyc;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result expected L+1 = 4 cycles after the closing beat was presented.
    task automatic exp_all(input logic [11:0] mx, input int i0, input int i1, input int i2,
                           input logic v0, input logic v1, input logic v2);
        e0.push_back(mk(drv_cyc + 4, mx, i0, v0));
        e1.push_back(mk(drv_cyc + 4, mx, i1, v1));
        e2.push_back(mk(drv_cyc + 4, mx, i2, v2));
    endtask

    task automatic cmp(input string tag, input res_t e[$], input res_t o[$]);
        check($sformatf("%s count", tag), o.size(), e.size());
        for (int i = 0; i < e.size() && i < o.size(); i++) begin
            check($sformatf("%s[%0d].cyc", tag, i), o[i].cyc, e[i].cyc);
            check($sformatf("%s[%0d].max", tag, i), 32'(o[i].mx), 32'(e[i].mx));
            check($sformatf("%s[%0d].idx", tag, i), 32'(o[i].idx), 32'(e[i].idx));
            check($sformatf("%s[%0d].ovf", tag, i), 32'(o[i].ovf), 32'(e[i].ovf));
        end
    endtask

    task automatic drain(input string tag);
        repeat (8) tick();
        cmp({tag, ".dut0"}, e0, o0);
        cmp({tag, ".dut1"}, e1, o1);
        cmp({tag, ".dut2"}, e2, o2);
        e0.delete(); e1.delete(); e2.delete();
        o0.delete(); o1.delete(); o2.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid0"}, 32'(if0.out_valid), 0);
        check({tag, " max0"}, 32'(if0.out_max), 0);
        check({tag, " idx0"}, 32'(if0.out_index), 0);
        check({tag, " ovf0"}, 32'(if0.out_overflow), 0);
        check({tag, " valid1"}, 32'(if1.out_valid), 0);
        check({tag, " max2"}, 32'(if2.out_max), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;

        tbl[0] = '{pk(5, -3, 100, 7, -2048, 2047, 0, 1),      12'h7FF, 5};
        tbl[1] = '{pk(-1, -1, -1, -1, -1, -1, -1, -1),         12'hFFF, 7};
        tbl[2] = '{pk(-5, -1, -9, -1, -2048, -7, -2, -3),      12'hFFF, 3};
        tbl[3] = '{pk(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048), 12'h800, 7};
        tbl[4] = '{pk(7, 0, 0, 0, 0, 0, 0, 0),                 12'd7,   0};
        tbl[5] = '{pk(2047, 2047, 0, 0, 0, 0, 0, 0),           12'h7FF, 1};
        tbl[6] = '{pk(1, 2, 3, 4, 5, 6, 7, 8),                 12'd8,   7};
        tbl[7] = '{pk(0, -1, -2, -3, -4, -5, -6, -2048),       12'd0,   0};

        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Back-to-back single-beat frames, then a stray beat with no frame open.
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, tbl[i].d);
            exp_all(tbl[i].mx, tbl[i].idx, tbl[i].idx + 2, tbl[i].idx, 1'b0, 1'b0, 1'b0);
        end
        beat(1'b0, 1'b1, pk(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047));
        drain("table");

        // Equal maxima in beat1 and beat2 with an idle gap: later beat wins.
        beat(1'b1, 1'b0, pk(100, 100, 100, 100, 100, 100, 100, 100));
        beat(1'b0, 1'b0, pk(100, 100, 100, 500, 100, 100, 100, 100));
        tick();
        beat(1'b0, 1'b1, pk(500, 100, 100, 100, 100, 100, 100, 100));
        exp_all(12'd500, 16, 18, 8, 1'b0, 1'b0, 1'b1);
        beat(1'b0, 1'b0, pk(2047, 0, 0, 0, 0, 0, 0, 0));
        drain("tie3");

        beat(1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        beat(1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        beat(1'b0, 1'b1, pk(0, 900, 0, 0, 0, 0, 0, 0));
        exp_all(12'd900, 17, 19, 9, 1'b0, 1'b0, 1'b1);
        drain("beat2");

        beat(1'b1, 1'b0, pk(10, 10, 10, 10, 10, 10, 10, 10));
        beat(1'b0, 1'b0, pk(10, 10, 10, 10, 10, 10, 10, 10));
        beat(1'b0, 1'b0, pk(10, 10, 10, 10, 10, 10, 10, 10));
        beat(1'b0, 1'b1, pk(10, 10, 10, 10, 10, 10, 300, 10));
        exp_all(12'd300, 30, 32, 14, 1'b0, 1'b0, 1'b1);
        drain("beat4");

        beat(1'b1, 1'b0, pk(1, 1, 50, 1, 1, 1, 1, 1));
        for (int b = 0; b < 3; b++) beat(1'b0, 1'b0, pk(1, 1, 1, 1, 1, 1, 1, 1));
        beat(1'b0, 1'b1, pk(1, 1, 1, 1, 1, 1, 1, 1));
        exp_all(12'd50, 2, 4, 2, 1'b1, 1'b1, 1'b1);
        drain("beat5");

        // New in_first abandons the open frame holding the larger value.
        beat(1'b1, 1'b0, pk(1000, 0, 0, 0, 0, 0, 0, 0));
        beat(1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        beat(1'b1, 1'b1, pk(0, 0, 0, 0, 3, 0, 0, 0));
        exp_all(12'd3, 4, 6, 4, 1'b0, 1'b0, 1'b0);
        drain("restart");

        // Reset with one result in flight and a frame open.
        beat(1'b1, 1'b1, pk(77, 77, 77, 77, 77, 77, 77, 77));
        beat(1'b1, 1'b0, pk(5, 5, 5, 5, 5, 5, 5, 5));
        reset = 1'b1;
        tick();
        tick();
        check_zero("midreset");
        reset = 1'b0;
        tick();
        beat(1'b0, 1'b1, pk(500, 500, 500, 500, 500, 500, 500, 500));
        drain("postreset");
        beat(1'b1, 1'b1, pk(0, 0, 9, 0, 0, 0, 0, 0));
        exp_all(12'd9, 2, 4, 2, 1'b0, 1'b0, 1'b0);
        drain("recover");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/soqpsk_argmax_tree.md
Name: soqpsk_argmax_tree

Overview:
Parametrised, pipelined signed argmax over N_IN parallel lanes per beat, with optional running maximum across a multi-beat frame. Used in the SOQPSK trellis/detector path to pick the winning metric and its global index from wide metric banks. Next generation of the 4-input comparator: arbitrary lane count, registered tree levels, frame accumulation, valid/first/last framing and an overflow flag.

Parameters:
WIDTH, 12, metric width, two's complement signed
N_IN, 8, lanes per beat; power of 2, 2..32
MAX_BEATS, 4, max beats per frame that index can represent; power of 2, >=1
IDX_W, 5, out_index width; must be >= clog2(INDEX_OFFSET + N_IN*MAX_BEATS)
INDEX_OFFSET, 0, constant added to every reported index

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  beat qualifier; no backpressure, every valid beat accepted
in_first  in  1  beat opens a frame (qualified by in_valid)
in_last  in  1  beat closes a frame (qualified by in_valid)
in_data  in  N_IN*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
out_valid  out  1  one-cycle pulse, frame result ready
out_max  out  WIDTH  largest signed value in frame
out_index  out  IDX_W  INDEX_OFFSET + beat*N_IN + lane of winner
out_overflow  out  1  frame exceeded MAX_BEATS beats

Behaviour:
- Reset: every output 0, all pipeline valids 0, frame closed, beat counter 0.
- Compare: signed full-width comparison, no arithmetic, no saturation. Tie: higher index wins (later lane in a beat, later beat across frame); matches existing comparator semantics.
- Tree: L = log2(N_IN) levels of pairwise nodes, each level registered; value, local lane index and first/last/valid flags travel together.
- Accumulator stage (1 register) after tree: on first beat loads beat winner; on later beats replaces held max when beat max >= held max (tie to later beat).
- Latency: in_valid&in_last at cycle t -> out_valid at t+L+1. Full throughput: one beat per cycle, back-to-back frames with no bubble.
- out_max/out_index/out_overflow update only with out_valid and hold otherwise.
- Beat counter (clog2(MAX_BEATS) bits, tracked at tree input): cleared on in_first, increments per accepted beat; on reaching MAX_BEATS it saturates at MAX_BEATS-1, the frame's overflow bit sets, and later beats are still compared but reported with the saturated beat number.
- in_first and in_last on same beat: single-beat frame.
- in_first while frame open: discard open frame, no output for it, start new frame.
- in_valid without in_first while no frame open: beat dropped, counter and accumulator unchanged.
- in_valid low: no state change except pipeline advance.
- Reset mid-frame or mid-pipeline: in-flight results discarded, no out_valid issued.

Decomposition:
- Package soqpsk_argmax_pkg: clog2 constant function, signed_ge(a,b) compare function (tie -> b), lane-slice helper.
- Sub-module soqpsk_argmax_node: one registered pairwise compare (value, index, valid); tree built with a generate loop over levels.
- Top holds framing logic, beat counter, accumulator, output registers.

Test Plan:
- N_IN=8, one beat first&last, lanes {5,-3,100,7,-2048,2047,0,1} -> 4 cycles later out_valid=1, out_max=2047, out_index=5.
- All lanes -1 (0xFFF) single beat -> out_max=-1, out_index=7; lanes {-5,-1,-9,-1,-2048,-7,-2,-3} -> out_max=-1, out_index=3.
- INDEX_OFFSET=2, 3-beat frame, 500 at beat1 lane3, 500 at beat2 lane0, all else <500 -> out_max=500, out_index=2+16+0=18 (tie to later beat).
- Back-to-back single-beat frames every cycle -> out_valid on consecutive cycles, each result correct; stray beat with no open frame -> no effect.
- in_first mid-frame -> earlier frame produces no out_valid; reset asserted during frame -> outputs 0, no out_valid afterwards.
- MAX_BEATS=2, 3-beat frame, max at beat2 lane1 -> out_overflow=1, out_index=INDEX_OFFSET+8+1.
